// File: rtl/exe_stage.sv
// exe_stage: execute stage with EX/MEM register and iterative MUL/DIV/REM sequencer.
// Define FAST_MUL_EN for a single-cycle combinational MUL; DIV/REM stay iterative.
module exe_stage #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            wb_en_in,
  input  logic [3:0]      ex_cmd_in,
  input  logic            branch_type_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic [XLEN-1:0] val1,
  input  logic [XLEN-1:0] val2,
  input  logic [XLEN-1:0] reg2,
  input  logic [4:0]      dst_in,
  output logic            stall,
  output logic            br_taken,
  output logic [XLEN-1:0] br_addr,
  output logic            wb_en_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] st_val,
  output logic [4:0]      dst_out,
  output logic [XLEN-1:0] pc_out
);
  localparam logic [3:0] ADD = 4'b0000, MUL = 4'b0001, SUB = 4'b0010, DIV = 4'b0011,
                         AND = 4'b0100, OR  = 4'b0101, NOR = 4'b0110, XOR = 4'b0111,
                         SLL = 4'b1000, SRA = 4'b1001, SRL = 4'b1010, REM = 4'b1011;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            state;
  logic [4:0]        cnt;
  logic [XLEN-1:0]   a_reg, b_reg, acc, abs1, abs2, mc_res, alu;
  logic [XLEN:0]     rem_try, diff;
  logic              s1, s2, dz, is_mul, is_div, is_rem, is_mc;
  logic [SHAMT_W-1:0] shamt;
  assign is_mul = ex_cmd_in == MUL;
  assign is_div = ex_cmd_in == DIV;
  assign is_rem = ex_cmd_in == REM;
`ifdef FAST_MUL_EN
  assign is_mc = is_div | is_rem;
`else
  assign is_mc = is_mul | is_div | is_rem;
`endif
  assign stall    = state == BUSY || (state == IDLE && is_mc);
  assign br_taken = branch_type_in & ~stall;
  assign br_addr  = pc_in + (val2 << 2);
  assign abs1     = val1[XLEN-1] ? -val1 : val1;
  assign abs2     = val2[XLEN-1] ? -val2 : val2;
  assign shamt    = val2[SHAMT_W-1:0];
  assign rem_try  = {acc, b_reg[XLEN-1]};
  assign diff     = rem_try - {1'b0, a_reg};
  // magnitudes are computed unsigned; signs are restored once the loop finishes
  assign mc_res = is_mul ? ((s1 ^ s2) ? -acc : acc) :
                  is_div ? (dz ? '1 : ((s1 ^ s2) ? -b_reg : b_reg)) :
                  (s1 ? -acc : acc);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (is_mc) begin
        a_reg <= is_mul ? abs1 : abs2;
        b_reg <= is_mul ? abs2 : abs1;
        acc   <= '0;
        cnt   <= '0;
        s1    <= val1[XLEN-1];
        s2    <= val2[XLEN-1];
        dz    <= val2 == '0;
        state <= BUSY;
      end
    end else if (state == BUSY) begin
      acc   <= is_mul ? acc + (b_reg[0] ? a_reg : '0) :
               (diff[XLEN] ? rem_try[XLEN-1:0] : diff[XLEN-1:0]);
      a_reg <= is_mul ? a_reg << 1 : a_reg;
      b_reg <= is_mul ? b_reg >> 1 : {b_reg[XLEN-2:0], ~diff[XLEN]};
      cnt   <= cnt + 5'd1;
      state <= cnt == 5'd31 ? DONE : BUSY;
    end else begin
      state <= IDLE;
    end
  end
  always_comb begin
    alu = '0;
    case (ex_cmd_in)
      ADD: alu = val1 + val2;
      SUB: alu = val1 - val2;
      AND: alu = val1 & val2;
      OR:  alu = val1 | val2;
      NOR: alu = ~(val1 | val2);
      XOR: alu = val1 ^ val2;
      SLL: alu = val1 << shamt;
      SRA: alu = $signed(val1) >>> shamt;
      SRL: alu = val1 >> shamt;
`ifdef FAST_MUL_EN
      MUL: alu = val1 * val2;
`else
      MUL: alu = mc_res;
`endif
      DIV, REM: alu = mc_res;
      default: alu = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst || stall) begin
      wb_en_out     <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
      alu_result    <= '0;
      st_val        <= '0;
      dst_out       <= '0;
      pc_out        <= '0;
    end else begin
      wb_en_out     <= wb_en_in;
      mem_read_out  <= mem_read_in;
      mem_write_out <= mem_write_in;
      alu_result    <= alu;
      st_val        <= reg2;
      dst_out       <= dst_in;
      pc_out        <= pc_in;
    end
  end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage pipeline.
- Consumes the ID/EX register outputs and computes the ALU result, branch target and store data.
- Its integrated EX/MEM register feeds the MEM stage.
- MUL/DIV/REM run on an iterative sequencer; stall freezes PC, IF/ID and ID/EX until the result is ready.

Parameters:
- XLEN, 32, datapath width; fixed at 32 for this core, other values unsupported.
- SHAMT_W, 5, shift-amount bits taken from val2[4:0].

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- pc_in  in  32  PC from ID/EX
- wb_en_in  in  1  write-back enable
- ex_cmd_in  in  4  ALU command
- branch_type_in  in  1  instruction is a taken branch
- mem_read_in  in  1  load
- mem_write_in  in  1  store
- val1  in  32  operand A
- val2  in  32  operand B (immediate or register)
- reg2  in  32  store data
- dst_in  in  5  destination register
- stall  out  1  combinational; freeze upstream stages
- br_taken  out  1  combinational; branch_type_in & ~stall
- br_addr  out  32  combinational; pc_in + (val2 << 2), wrapping mod 2^32
- wb_en_out  out  1  EX/MEM
- mem_read_out  out  1  EX/MEM
- mem_write_out  out  1  EX/MEM
- alu_result  out  32  EX/MEM
- st_val  out  32  EX/MEM, registered reg2
- dst_out  out  5  EX/MEM
- pc_out  out  32  EX/MEM

Behaviour:
- ex_cmd encoding:
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR.
  - 1000 SLL, 1001 SRA, 1010 SRL; shifts use val2[4:0].
  - 0001 MUL: low 32 bits of signed product.
  - 0011 DIV: signed quotient, truncated toward zero.
  - 1011 REM: signed remainder, takes the sign of the dividend.
  - Any other code: result 0.
- All add/sub arithmetic wraps mod 2^32; no overflow flag.
- Single-cycle ops: result is registered into EX/MEM on the next rising edge (latency 1). stall = 0.
- Multi-cycle sequencer states IDLE, BUSY, DONE:
  - IDLE: if ex_cmd is MUL/DIV/REM, stall = 1; latch |val1| and |val2| plus the sign bits; clear the 5-bit iteration counter; go to BUSY.
  - BUSY: stall = 1; one shift-add (MUL) or restoring-subtract (DIV/REM) iteration per cycle. When counter = 31, go to DONE; otherwise increment the counter.
  - DONE: stall = 0; apply sign correction to the result; EX/MEM captures it; go to IDLE. The same instruction is still present because upstream was frozen, so DONE never restarts an op.
- Multi-cycle latency: the instruction occupies EXE for 34 cycles (1 IDLE + 32 BUSY + 1 DONE); the result is visible at EX/MEM after the 34th edge.
- While stall = 1, EX/MEM loads a bubble: wb_en_out, mem_read_out and mem_write_out = 0; other fields zeroed.
- Divide by zero: quotient = 32'hFFFFFFFF, remainder = val1; same 34-cycle latency, no trap.
- 0x80000000 / -1: quotient 0x80000000, remainder 0.
- br_taken is forced to 0 while stall = 1.
- Reset:
  - rst has priority over everything, including mid-BUSY.
  - Sequencer goes to IDLE, counter 0, in-flight op discarded.
  - All EX/MEM outputs reset to 0.
  - stall = 0 in the cycle after reset.

Optional Feature:
- FAST_MUL_EN defined: MUL uses a combinational 32x32 multiplier and behaves as a single-cycle op (stall = 0, latency 1). DIV/REM remain iterative.
- FAST_MUL_EN undefined: MUL uses the iterative sequencer, 34-cycle occupancy, as above.

Test Plan:
- ADD val1 = 7, val2 = 0xFFFFFFFE, wb_en = 1, dst = 3 -> next edge: alu_result = 5, wb_en_out = 1, dst_out = 3, stall = 0 throughout.
- SRA val1 = 0x80000000, val2 = 4 -> alu_result = 0xF8000000. SRL with the same operands -> 0x08000000.
- MUL val1 = -6, val2 = 7 (FAST_MUL_EN undefined) -> stall = 1 for 33 cycles, bubbles in EX/MEM; after the 34th edge alu_result = 0xFFFFFFD6 (-42). With FAST_MUL_EN defined -> result after 1 edge, no stall.
- DIV val1 = -7, val2 = 2 -> quotient 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). DIV by 0 -> 0xFFFFFFFF. REM by 0 -> val1.
- DIV started, rst asserted at BUSY cycle 10 -> next edge: all outputs 0, stall = 0. A following ADD completes in 1 cycle.
- branch_type_in = 1, pc_in = 0x100, val2 = 4 -> br_taken = 1, br_addr = 0x110. The same branch presented during a DIV stall -> br_taken = 0.
